pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised decode/execute-style pipeline stage register with a valid/ready handshake and a one-entry skid buffer. It replaces fixed-field, enable-driven stage registers with a generic payload of WIDTH bits. It sustains full throughput under back-pressure, and it zeroes flushed or drained slots so that a bubble is always an all-zero payload (NOP). It is instantiated between any two pipeline stages, for example decode→execute carrying scalar plus 128-bit vector operands.

## Interface
- WIDTH, 32: payload width in bits (≥1); the full D→E bundle is packed into one vector.
- clock  in  1  rising-edge clock.
- async_reset  in  1  reset, asynchronous, active-low; clears everything.
- sync_reset  in  1  synchronous flush, active-low; sampled on clock.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept; registered (equals NOT skid_valid).
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  main slot holds a valid payload.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  WIDTH  main slot payload; all-zero whenever out_valid=0.
- stall_count  out  32  only with PIPE_STAGE_SKID_PERF_EN; see Configuration.
- bubble_count  out  32  only with PIPE_STAGE_SKID_PERF_EN; see Configuration.

## Operation
- State: main slot (main_valid, main_data) and skid slot (skid_valid, skid_data). The two slots give 3 occupancy states:
  - EMPTY: 0 valid entries.
  - ONE: main valid.
  - FULL: main and skid valid.
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Transitions, in priority order, when sync_reset=1:
  - EMPTY: if in_fire, main←in_data → ONE; otherwise stay EMPTY.
  - ONE with out_fire and in_fire: main←in_data, stay ONE.
  - ONE with out_fire and no in_fire: main←0 → EMPTY.
  - ONE with no out_fire and in_fire: skid←in_data → FULL.
  - ONE with neither: hold.
  - FULL with out_fire: main←skid_data, skid←0 → ONE. in_ready is 0 in FULL, so no in_fire can occur.
  - FULL with no out_fire: hold.
- Flush (sync_reset=0) overrides everything:
  - Both valids are cleared and both data registers are zeroed.
  - Any in_fire in the flush cycle is discarded.
  - out_fire in the flush cycle still counts as consumed downstream.
- The payload is never modified, reordered or duplicated. Ordering is strict FIFO.
- in_valid with in_ready=0 has no effect. Upstream must hold in_data stable until in_fire; this is not checked.

## Timing
- Reset values (async_reset=0): out_valid=0, out_data=0, in_ready=1, skid cleared, counters 0.
- Latency: 1 cycle. in_fire at edge N gives out_valid=1 with that data after edge N.
- Throughput: 1 transfer/cycle whenever out_ready=1.
- in_ready falls the cycle after the skid fills. It rises the cycle after the skid drains or a flush occurs.
- Asynchronous reset mid-transfer drops both entries immediately, without waiting for a clock edge.
- Boundary cases:
  - Flush while FULL: 2 payloads are lost and the next state is EMPTY.
  - Flush asserted for consecutive cycles: the stage stays EMPTY.
  - out_ready held low indefinitely: FULL is held, nothing is overwritten.

## Configuration
- PIPE_STAGE_SKID_PERF_EN defined:
  - stall_count increments each cycle with out_valid & !out_ready.
  - bubble_count increments each cycle with !out_valid.
  - Both are 32-bit and saturate at 32'hFFFF_FFFF.
  - Both are cleared only by async_reset, not by flush.
- Not defined: the ports and counter logic are absent, and the datapath behaviour is identical.

## Structure
- Package pipe_stage_pkg holds:
  - PERF_CNT_W = 32.
  - Occupancy enum pipe_occ_e {OCC_EMPTY, OCC_ONE, OCC_FULL}.
  - Bubble constant function (all-zero payload of a given width).
- Sub-module pipe_sat_counter: a PERF_CNT_W saturating counter with increment enable and async active-low clear. It is instantiated twice under the macro.

## Test plan
- Reset: async_reset=0 mid-cycle with FULL state → out_valid=0, out_data=0, in_ready=1 immediately; counters 0.
- Streaming, WIDTH=8, out_ready=1: inputs 0x11, 0x22, 0x33 on consecutive cycles → out_data 0x11, 0x22, 0x33 one cycle later each, no gaps, in_ready stays 1.
- Back-pressure:
  - Stimulus: send 0xA1 then 0xA2, out_ready=0.
  - Response: FULL, in_ready=0 next cycle, out_data holds 0xA1.
  - Then raise out_ready: 0xA1, then 0xA2, then out_valid=0 with out_data=0x00.
- Flush:
  - Stimulus: FULL with 0x5A/0x5B; sync_reset=0 for one cycle while in_valid=1 with 0x77.
  - Response: EMPTY, out_data=0, 0x77 is not delivered, in_ready=1 next cycle.
- Skid drain with simultaneous input:
  - Stimulus: FULL; out_ready=1 while in_valid=1 with 0x99.
  - Response: main←skid, 0x99 is not accepted (in_ready=0), and 0x99 is accepted on the following cycle.
- Perf (macro on): 5 cycles of out_valid=1/out_ready=0 followed by 3 idle cycles → stall_count=5, bubble_count=3. Forced near-max value saturates at FFFF_FFFF.

Source files
------------

// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and constants for the skid-buffered pipeline stage.
package pipe_stage_pkg;

  localparam int PERF_CNT_W = 32;
  localparam int PIPE_MAX_W = 4096;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } pipe_occ_e;

  // NOP payload: every bit zero; callers size-cast it to their payload width.
  function automatic logic [PIPE_MAX_W-1:0] bubble_payload(input int width);
    logic [PIPE_MAX_W-1:0] lane_mask;
    lane_mask = ~({PIPE_MAX_W{1'b1}} << width);
    return {PIPE_MAX_W{1'b0}} & lane_mask;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating event counter with enable and asynchronous active-low clear.
module pipe_sat_counter
  import pipe_stage_pkg::*;
(
  input  logic                  clock,
  input  logic                  async_reset,
  input  logic                  inc_en,
  output logic [PERF_CNT_W-1:0] count
);

  // Sticks at all-ones instead of wrapping so long runs stay meaningful.
  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      count <= '0;
    end else if (inc_en && (count != {PERF_CNT_W{1'b1}})) begin
      count <= count + PERF_CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a one-entry skid buffer and zeroed bubbles.
// Optional perf counters are built when PIPE_STAGE_SKID_PERF_EN is defined.
module pipe_stage_skid
  import pipe_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             async_reset,
  input  logic             sync_reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_SKID_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] stall_count,
  output logic [PERF_CNT_W-1:0] bubble_count
`endif
);

  localparam logic [WIDTH-1:0] BUBBLE = WIDTH'(bubble_payload(WIDTH));

  pipe_occ_e        occ_q, occ_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             main_valid, skid_valid;
  logic             in_fire, out_fire;

  assign main_valid = (occ_q != OCC_EMPTY);
  assign skid_valid = (occ_q == OCC_FULL);
  assign in_ready   = ~skid_valid;
  assign out_valid  = main_valid;
  assign out_data   = main_data_q;
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;

  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      occ_q       <= OCC_EMPTY;
      main_data_q <= BUBBLE;
      skid_data_q <= BUBBLE;
    end else begin
      occ_q       <= occ_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

  // Every slot that empties is rewritten with BUBBLE so out_data is zero when idle.
  always_comb begin
    occ_d       = occ_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (!sync_reset) begin
      occ_d       = OCC_EMPTY;
      main_data_d = BUBBLE;
      skid_data_d = BUBBLE;
    end else begin
      unique case (occ_q)
        OCC_EMPTY: begin
          if (in_fire) begin
            main_data_d = in_data;
            occ_d       = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (out_fire && in_fire) begin
            main_data_d = in_data;
          end else if (out_fire) begin
            main_data_d = BUBBLE;
            occ_d       = OCC_EMPTY;
          end else if (in_fire) begin
            skid_data_d = in_data;
            occ_d       = OCC_FULL;
          end
        end
        OCC_FULL: begin
          if (out_fire) begin
            main_data_d = skid_data_q;
            skid_data_d = BUBBLE;
            occ_d       = OCC_ONE;
          end
        end
        default: begin
          occ_d       = OCC_EMPTY;
          main_data_d = BUBBLE;
          skid_data_d = BUBBLE;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_SKID_PERF_EN
  pipe_sat_counter u_stall_count (
    .clock       (clock),
    .async_reset (async_reset),
    .inc_en      (out_valid & ~out_ready),
    .count       (stall_count)
  );

  pipe_sat_counter u_bubble_count (
    .clock       (clock),
    .async_reset (async_reset),
    .inc_en      (~out_valid),
    .count       (bubble_count)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: directed vector table, reset/perf sequences,
// and random traffic checked against a two-deep FIFO reference model.
module tb_pipe_stage_skid;

  logic       clock;
  logic       async_reset;
  logic       sync_reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
`ifdef PIPE_STAGE_SKID_PERF_EN
  logic [31:0] stall_count;
  logic [31:0] bubble_count;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] model_q[$];

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       srst;
    logic       exp_ov;
    logic [7:0] exp_od;
    logic       exp_ir;
  } vec_t;

  vec_t vecs[$];

  pipe_stage_skid #(.WIDTH(8)) dut (
    .clock        (clock),
    .async_reset  (async_reset),
    .sync_reset   (sync_reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data)
`ifdef PIPE_STAGE_SKID_PERF_EN
    ,
    .stall_count  (stall_count),
    .bubble_count (bubble_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle of inputs, let the edge happen, advance the reference FIFO.
  task automatic applyStimulus(input logic iv, input logic [7:0] id,
                               input logic ordy, input logic srst);
    logic m_in_fire, m_out_fire;
    in_valid   = iv;
    in_data    = id;
    out_ready  = ordy;
    sync_reset = srst;
    m_in_fire  = iv && (model_q.size() < 2);
    m_out_fire = ordy && (model_q.size() > 0);
    @(posedge clock);
    if (!srst) begin
      model_q.delete();
    end else begin
      if (m_out_fire) void'(model_q.pop_front());
      if (m_in_fire) model_q.push_back(id);
    end
    @(negedge clock);
  endtask

  task automatic checkOutput(input string name, input logic exp_ov,
                             input logic [7:0] exp_od, input logic exp_ir);
    total++;
    if (out_valid !== exp_ov || out_data !== exp_od || in_ready !== exp_ir) begin
      bad++;
      $display("[TB] FAIL %s: got valid=%b data=%02h ready=%b, want valid=%b data=%02h ready=%b",
               name, out_valid, out_data, in_ready, exp_ov, exp_od, exp_ir);
    end
  endtask

  task automatic checkModel(input string name);
    logic [7:0] head;
    head = (model_q.size() > 0) ? model_q[0] : 8'h00;
    checkOutput(name, model_q.size() > 0, head, model_q.size() < 2);
  endtask

  task automatic checkValue(input string name, input logic [31:0] got,
                            input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %08h want %08h", name, got, want);
    end
  endtask

  initial begin
`ifdef PIPE_STAGE_SKID_PERF_EN
    logic [31:0] stall_base, bubble_base;
`endif
    async_reset = 1'b0;
    sync_reset  = 1'b1;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    out_ready   = 1'b0;

    //          iv    id     ordy  srst  ov    od     ir
    vecs.push_back('{1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1});
    vecs.push_back('{1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1});
    vecs.push_back('{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b1});
    vecs.push_back('{1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b0});
    vecs.push_back('{1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA2, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1});
    vecs.push_back('{1'b1, 8'h5B, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0});
    vecs.push_back('{1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{1'b1, 8'hC1, 1'b0, 1'b1, 1'b1, 8'hC1, 1'b1});
    vecs.push_back('{1'b1, 8'hC2, 1'b0, 1'b1, 1'b1, 8'hC1, 1'b0});
    vecs.push_back('{1'b1, 8'h99, 1'b1, 1'b1, 1'b1, 8'hC2, 1'b1});
    vecs.push_back('{1'b1, 8'h99, 1'b0, 1'b1, 1'b1, 8'hC2, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h99, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1});

    repeat (2) @(negedge clock);
    checkOutput("reset_held", 1'b0, 8'h00, 1'b1);
    async_reset = 1'b1;
    @(negedge clock);
    checkOutput("after_reset", 1'b0, 8'h00, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].srst);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_od, vecs[i].exp_ir);
    end

    // Asynchronous reset in the middle of a FULL cycle must act before any edge.
    applyStimulus(1'b1, 8'hE1, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'hE2, 1'b0, 1'b1);
    checkOutput("full_before_areset", 1'b1, 8'hE1, 1'b0);
    in_valid = 1'b0;
    @(posedge clock);
    #2 async_reset = 1'b0;
    #1 checkOutput("areset_immediate", 1'b0, 8'h00, 1'b1);
`ifdef PIPE_STAGE_SKID_PERF_EN
    checkValue("areset_stall_cnt", stall_count, 32'h0);
    checkValue("areset_bubble_cnt", bubble_count, 32'h0);
`endif
    model_q.delete();
    @(negedge clock);
    async_reset = 1'b1;
    @(negedge clock);
    checkOutput("after_areset", 1'b0, 8'h00, 1'b1);

`ifdef PIPE_STAGE_SKID_PERF_EN
    applyStimulus(1'b1, 8'h42, 1'b0, 1'b1);
    stall_base  = stall_count;
    bubble_base = bubble_count;
    repeat (5) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkValue("perf_stall_delta", stall_count - stall_base, 32'd5);
    checkValue("perf_bubble_delta", bubble_count - bubble_base, 32'd3);

    applyStimulus(1'b1, 8'h43, 1'b0, 1'b1);
    force dut.u_stall_count.count = 32'hFFFF_FFFD;
    #1 release dut.u_stall_count.count;
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkValue("perf_saturate", stall_count, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
`endif

    // Random traffic against the FIFO reference, with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 15) != 0));
      checkModel($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
